// File: rtl/ifft008_seq.sv
// 8-point inverse DFT, one radix-2 DIF butterfly per clock over an 8-entry
// in-place sample store; streams in natural order with valid/ready handshakes.
module ifft008_seq (
    input  logic        ck,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_last,
    input  logic        out_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        UNLOAD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] mem_q [8];

    logic [2:0]  lo_idx, hi_idx, rd_idx;
    logic [1:0]  tw_sel;
    logic signed [15:0] a_re, a_im, b_re, b_im, w_re, w_im;
    logic signed [16:0] s_re, s_im, d_re_w, d_im_w;
    logic signed [15:0] d_re, d_im;
    logic signed [31:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [32:0] m_re, m_im;
    logic [31:0] upper_res, lower_res;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (cnt_q == 4'd7) begin
                        state_d = COMPUTE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            COMPUTE: begin
                busy = 1'b1;
                if (cnt_q == 4'd11) begin
                    state_d = UNLOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            UNLOAD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = (cnt_q == 4'd7);
                if (out_ready) begin
                    if (cnt_q == 4'd7) begin
                        state_d = LOAD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = LOAD;
                cnt_d   = '0;
            end
        endcase
    end

    // cnt_q[3:2] selects the stage, cnt_q[1:0] the butterfly within it
    always_comb begin
        lo_idx = '0;
        hi_idx = '0;
        tw_sel = '0;
        case (cnt_q[3:2])
            2'd0: begin
                lo_idx = {1'b0, cnt_q[1:0]};
                hi_idx = {1'b1, cnt_q[1:0]};
                tw_sel = cnt_q[1:0];
            end
            2'd1: begin
                lo_idx = {cnt_q[1], 1'b0, cnt_q[0]};
                hi_idx = {cnt_q[1], 1'b1, cnt_q[0]};
                tw_sel = {cnt_q[0], 1'b0};
            end
            default: begin
                lo_idx = {cnt_q[1:0], 1'b0};
                hi_idx = {cnt_q[1:0], 1'b1};
                tw_sel = 2'd0;
            end
        endcase
    end

    always_comb begin
        w_re = 16'sh0800;
        w_im = 16'sh0000;
        case (tw_sel)
            2'd1: begin w_re = 16'sh05A8; w_im = 16'sh05A8; end
            2'd2: begin w_re = 16'sh0000; w_im = 16'sh0800; end
            2'd3: begin w_re = 16'shFA58; w_im = 16'sh05A8; end
            default: begin w_re = 16'sh0800; w_im = 16'sh0000; end
        endcase
    end

    always_comb begin
        a_re   = mem_q[lo_idx][31:16];
        a_im   = mem_q[lo_idx][15:0];
        b_re   = mem_q[hi_idx][31:16];
        b_im   = mem_q[hi_idx][15:0];
        s_re   = 17'(a_re) + 17'(b_re);
        s_im   = 17'(a_im) + 17'(b_im);
        d_re_w = 17'(a_re) - 17'(b_re);
        d_im_w = 17'(a_im) - 17'(b_im);
        // taking bits [16:1] is the arithmetic >>1 followed by 16-bit truncation
        d_re   = d_re_w[16:1];
        d_im   = d_im_w[16:1];
        p_rr   = 32'(d_re) * 32'(w_re);
        p_ii   = 32'(d_im) * 32'(w_im);
        p_ri   = 32'(d_re) * 32'(w_im);
        p_ir   = 32'(d_im) * 32'(w_re);
        m_re   = 33'(p_rr) - 33'(p_ii);
        m_im   = 33'(p_ri) + 33'(p_ir);
        upper_res = {s_re[16:1], s_im[16:1]};
        lower_res = {m_re[26:11], m_im[26:11]};
    end

    always_ff @(posedge ck) begin
        if (state_q == LOAD && in_valid) begin
            mem_q[cnt_q[2:0]] <= in_data;
        end else if (state_q == COMPUTE) begin
            mem_q[lo_idx] <= upper_res;
            mem_q[hi_idx] <= lower_res;
        end
    end

    assign rd_idx = {cnt_q[0], cnt_q[1], cnt_q[2]};

    always_comb begin
        out_data = '0;
        if (state_q == UNLOAD) begin
            out_data = mem_q[rd_idx];
        end
    end

endmodule

// File: tb/tb_ifft008_seq.sv
// Randomized self-checking bench for ifft008_seq against a stage-loop IDFT model.
module tb_ifft008_seq;

    logic        ck = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    ifft008_seq dut (
        .ck        (ck),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 ck = ~ck;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [31:0] x [8], output logic [31:0] y [8]);
        logic signed [15:0] re [8];
        logic signed [15:0] im [8];
        int wr [4];
        int wi [4];
        int a, b, tw, sr, si, dr, di, br;
        longint pr, pim;
        wr = '{32'sh0800, 32'sh05A8, 32'sh0000, -32'sh05A8};
        wi = '{32'sh0000, 32'sh05A8, 32'sh0800, 32'sh05A8};
        for (int n = 0; n < 8; n++) begin
            re[n] = x[n][31:16];
            im[n] = x[n][15:0];
        end
        for (int span = 4; span >= 1; span = span / 2) begin
            for (int base = 0; base < 8; base += 2 * span) begin
                for (int j = 0; j < span; j++) begin
                    a  = base + j;
                    b  = a + span;
                    tw = j * (4 / span);
                    sr = (int'(re[a]) + int'(re[b])) >>> 1;
                    si = (int'(im[a]) + int'(im[b])) >>> 1;
                    dr = int'(16'(((int'(re[a]) - int'(re[b])) >>> 1)));
                    di = int'(16'(((int'(im[a]) - int'(im[b])) >>> 1)));
                    dr = int'($signed(16'(dr)));
                    di = int'($signed(16'(di)));
                    pr  = longint'(dr) * longint'(wr[tw]) - longint'(di) * longint'(wi[tw]);
                    pim = longint'(dr) * longint'(wi[tw]) + longint'(di) * longint'(wr[tw]);
                    re[a] = 16'(sr);
                    im[a] = 16'(si);
                    re[b] = 16'(pr >>> 11);
                    im[b] = 16'(pim >>> 11);
                end
            end
        end
        for (int k = 0; k < 8; k++) begin
            br = ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
            y[k] = {re[br], im[br]};
        end
    endtask

    task automatic send_frame(input logic [31:0] x [8], input int gapmax);
        for (int n = 0; n < 8; n++) begin
            repeat ($urandom_range(gapmax, 0)) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                @(posedge ck); #1;
            end
            check("in_ready_load", in_ready, 1);
            in_valid = 1'b1;
            in_data  = x[n];
            @(posedge ck); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic recv_frame(input int stall_at, output logic [31:0] got [8]);
        int n;
        logic [31:0] hd;
        logic hl;
        for (int k = 0; k < 8; k++) got[k] = '0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge ck); #1;
            n++;
        end
        check("latency", n, 12);
        for (int k = 0; k < 8; k++) begin
            n = 0;
            while (!out_valid && n < 40) begin
                @(posedge ck); #1;
                n++;
            end
            if (!out_valid) begin
                check("out_timeout", 0, 1);
                return;
            end
            if (k == stall_at) begin
                hd = out_data;
                hl = out_last;
                out_ready = 1'b0;
                repeat (5) begin
                    @(posedge ck); #1;
                    check("stall_valid", out_valid, 1);
                    check("stall_data", out_data, hd);
                    check("stall_last", out_last, hl);
                    check("stall_in_ready", in_ready, 0);
                end
                out_ready = 1'b1;
            end
            got[k] = out_data;
            check("out_last", out_last, (k == 7));
            check("busy_unload", busy, 1);
            @(posedge ck); #1;
        end
        check("in_ready_next", in_ready, 1);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        logic [31:0] x [8];
        logic [31:0] y [8];
        logic [31:0] got [8];
        logic [31:0] x2 [8];
        logic [31:0] y2 [8];

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        repeat (3) @(posedge ck);
        #1 rst_n = 1'b1;
        @(posedge ck); #1;

        // impulse
        for (int n = 0; n < 8; n++) x[n] = '0;
        x[0] = 32'h0800_0000;
        send_frame(x, 0);
        recv_frame(-1, got);
        for (int k = 0; k < 8; k++) check("impulse", got[k], 32'h0100_0000);

        // DC
        for (int n = 0; n < 8; n++) x[n] = 32'h0800_0000;
        send_frame(x, 1);
        recv_frame(-1, got);
        check("dc0", got[0], 32'h0800_0000);
        for (int k = 1; k < 8; k++) check("dc_rest", got[k], 32'h0);

        // shifted impulse
        for (int n = 0; n < 8; n++) x[n] = '0;
        x[1] = 32'h0800_0000;
        model(x, y);
        send_frame(x, 2);
        recv_frame(-1, got);
        check("shift0", got[0], 32'h0100_0000);
        check("shift1", got[1], 32'h00B5_00B5);
        check("shift2", got[2], 32'h0000_0100);
        check("shift4", got[4], 32'hFF00_0000);
        for (int k = 0; k < 8; k++) check("shift_model", got[k], y[k]);

        // backpressure after third output
        for (int n = 0; n < 8; n++) x[n] = $urandom;
        model(x, y);
        send_frame(x, 1);
        recv_frame(3, got);
        for (int k = 0; k < 8; k++) check("bp_model", got[k], y[k]);

        // reset during the sixth COMPUTE cycle
        for (int n = 0; n < 8; n++) x[n] = $urandom;
        send_frame(x, 0);
        repeat (5) @(posedge ck);
        #1 check("busy_compute", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_last", out_last, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 1);
        @(posedge ck); #1 rst_n = 1'b1;
        @(posedge ck); #1;
        check("post_rst_in_ready", in_ready, 1);
        for (int n = 0; n < 8; n++) x[n] = '0;
        x[0] = 32'h0800_0000;
        send_frame(x, 0);
        recv_frame(-1, got);
        for (int k = 0; k < 8; k++) check("post_rst_impulse", got[k], 32'h0100_0000);

        // two back-to-back random frames with input gaps
        for (int n = 0; n < 8; n++) begin
            x[n]  = $urandom;
            x2[n] = $urandom;
        end
        model(x, y);
        model(x2, y2);
        send_frame(x, 3);
        recv_frame(-1, got);
        for (int k = 0; k < 8; k++) check("b2b_f1", got[k], y[k]);
        send_frame(x2, 3);
        recv_frame(-1, got);
        for (int k = 0; k < 8; k++) check("b2b_f2", got[k], y2[k]);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
